unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
Multicycle control FSM that sequences the RV64 processing unit (PC, IR, register file, A/B, ALUOut, MDR, data memory). It decodes the opcode/funct fields latched in IR, walks each instruction through fetch/decode/execute/memory/writeback, and drives every load-enable, mux select and ALU function of the datapath. Its state is exported for bench monitoring.

Parameters:
STATE_W, 5, width of exported state code (encodings below fit in 5 bits)

Ports:
clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high; sampled on clk rising edge
Instr6_0  in  7  opcode from IR
Funct3  in  3  IR[14:12]
Funct7_5  in  1  IR[30] (sub vs add)
Zero  in  1  ALU zero flag, combinational from datapath
PCWrite  out  1  load PC
IRWrite  out  1  load IR from instruction memory
RegWrite  out  1  register file write
DMemWrite  out  1  data memory write (0 = read)
LoadAB  out  1  load A and B registers
LoadALUOut  out  1  load ALUOut register
LoadMDR  out  1  load memory data register
ALUSrcA  out  2  00 PC, 01 A
ALUSrcB  out  2  00 B, 01 const 4, 10 immediate
ALUFunct  out  3  000 passB, 001 add, 010 sub, 011 and, 100 or, 101 xor
MemToReg  out  2  00 ALUOut, 01 MDR, 10 PC, 11 immediate
PCSource  out  2  00 ALU result, 01 ALUOut
state  out  STATE_W  current state code
Error  out  1  high while in ERROR state

Behaviour:
- States/codes: RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, LOAD_READ 4, LOAD_WB 5, STORE 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JAL 12, JALR 13, LUI 14, ERROR 15.
- Reset=1 at a clk edge -> state=RESET next cycle, from any state (including mid-instruction). In RESET, every output is 0. RESET -> FETCH on the first edge with Reset=0.
- All outputs not listed for a state are 0. Outputs are Moore (decoded from state only), except PCWrite in BRANCH.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUFunct=add, PCSource=00 -> DECODE.
- DECODE: LoadAB=1, LoadALUOut=1, ALUSrcA=00, ALUSrcB=10, add (branch target precomputed). Dispatch on Instr6_0:
  - 0110011 -> R_EXEC
  - 0010011 -> I_EXEC
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other value -> ERROR
- R_EXEC: ALUSrcA=01, ALUSrcB=00, LoadALUOut=1. Funct3 000 -> add, or sub if Funct7_5=1; 111 -> and; 110 -> or; 100 -> xor; any other Funct3 -> ERROR. R_EXEC -> R_WB.
- I_EXEC: same as R_EXEC but ALUSrcB=10 and Funct7_5 ignored (always add for 000) -> I_WB.
- R_WB / I_WB: RegWrite=1, MemToReg=00 -> FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, add, LoadALUOut=1 -> LOAD_READ if opcode is 0000011, else STORE.
- LOAD_READ: LoadMDR=1 -> LOAD_WB. LOAD_WB: RegWrite=1, MemToReg=01 -> FETCH.
- STORE: DMemWrite=1 for exactly one cycle -> FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, sub, PCSource=01. PCWrite = Zero when Funct3=000 (beq); PCWrite = ~Zero when Funct3=001 (bne); any other Funct3 -> ERROR with PCWrite=0. Otherwise BRANCH -> FETCH.
- JAL: RegWrite=1, MemToReg=10, PCWrite=1, PCSource=01 -> FETCH.
- JALR: RegWrite=1, MemToReg=10, ALUSrcA=01, ALUSrcB=10, add, PCWrite=1, PCSource=00 -> FETCH.
- LUI: RegWrite=1, MemToReg=11 -> FETCH.
- ERROR: Error=1, all write enables 0; held until Reset.
- Latency in cycles from FETCH to next FETCH: R/I 4, load 5, store 4, branch 3, jal/jalr/lui 3.
- Reset has priority over every transition.

Test Plan:
- Reset held 2 cycles -> state=0 and all outputs 0; first edge after release -> state=1 with IRWrite=1 and PCWrite=1.
- Instr6_0=0110011, Funct3=000, Funct7_5=1 -> states 1,2,7,8,1; ALUFunct=010 in state 7; RegWrite=1 only in state 8.
- Instr6_0=0000011 -> states 1,2,3,4,5,1; LoadMDR=1 in state 4; MemToReg=01 with RegWrite=1 in state 5. Instr6_0=0100011 -> DMemWrite=1 only in state 6.
- Instr6_0=1100011, Funct3=000: Zero=1 -> PCWrite=1 and PCSource=01 in state 11; Zero=0 -> PCWrite=0. Funct3=001 gives the inverse result.
- Instr6_0=1111111 -> state 15 with Error=1, stays there for 10 cycles with no write enables; Reset -> state 0.
- Reset asserted while in state 4 -> state 0 next edge with LoadMDR=0 and RegWrite=0; normal fetch resumes after release.

Source files
------------

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bundle between the multicycle controller and the RV64 datapath.
// master = controller (reads IR fields/Zero, drives enables/selects), slave = datapath.
interface unidade_controle_multiciclo_if #(
   parameter int STATE_W = 5
);
   logic [6:0]         Instr6_0;
   logic [2:0]         Funct3;
   logic               Funct7_5;
   logic               Zero;
   logic               PCWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic               DMemWrite;
   logic               LoadAB;
   logic               LoadALUOut;
   logic               LoadMDR;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         ALUFunct;
   logic [1:0]         MemToReg;
   logic [1:0]         PCSource;
   logic [STATE_W-1:0] state;
   logic               Error;

   modport master (
      input  Instr6_0, Funct3, Funct7_5, Zero,
      output PCWrite, IRWrite, RegWrite, DMemWrite, LoadAB, LoadALUOut, LoadMDR,
             ALUSrcA, ALUSrcB, ALUFunct, MemToReg, PCSource, state, Error
   );

   modport slave (
      output Instr6_0, Funct3, Funct7_5, Zero,
      input  PCWrite, IRWrite, RegWrite, DMemWrite, LoadAB, LoadALUOut, LoadMDR,
             ALUSrcA, ALUSrcB, ALUFunct, MemToReg, PCSource, state, Error
   );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RV64 control FSM: fetch/decode/execute/memory/writeback sequencing.
// Outputs are Moore-decoded from state, except PCWrite in BRANCH which follows Zero.
module unidade_controle_multiciclo #(
   parameter int STATE_W = 5
) (
   input logic                          clk,
   input logic                          Reset,
   unidade_controle_multiciclo_if.master ctrl
);
   localparam logic [4:0] S_RESET     = 5'd0;
   localparam logic [4:0] S_FETCH     = 5'd1;
   localparam logic [4:0] S_DECODE    = 5'd2;
   localparam logic [4:0] S_MEM_ADDR  = 5'd3;
   localparam logic [4:0] S_LOAD_READ = 5'd4;
   localparam logic [4:0] S_LOAD_WB   = 5'd5;
   localparam logic [4:0] S_STORE     = 5'd6;
   localparam logic [4:0] S_R_EXEC    = 5'd7;
   localparam logic [4:0] S_R_WB      = 5'd8;
   localparam logic [4:0] S_I_EXEC    = 5'd9;
   localparam logic [4:0] S_I_WB      = 5'd10;
   localparam logic [4:0] S_BRANCH    = 5'd11;
   localparam logic [4:0] S_JAL       = 5'd12;
   localparam logic [4:0] S_JALR      = 5'd13;
   localparam logic [4:0] S_LUI       = 5'd14;
   localparam logic [4:0] S_ERROR     = 5'd15;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_XOR   = 3'b101;

   logic [4:0] state_q;
   logic [4:0] state_d;
   logic [2:0] arith_funct;
   logic       arith_ok;
   logic       branch_ok;
   logic       branch_taken;

   // Arithmetic decode shared by R and I; Funct7_5 selects sub only for R-type.
   always_comb begin
      arith_ok    = 1'b1;
      arith_funct = ALU_PASSB;
      case (ctrl.Funct3)
         3'b000:  arith_funct = (state_q == S_R_EXEC && ctrl.Funct7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  arith_funct = ALU_AND;
         3'b110:  arith_funct = ALU_OR;
         3'b100:  arith_funct = ALU_XOR;
         default: arith_ok    = 1'b0;
      endcase
   end

   always_comb begin
      branch_ok    = 1'b0;
      branch_taken = 1'b0;
      case (ctrl.Funct3)
         3'b000: begin
            branch_ok    = 1'b1;
            branch_taken = ctrl.Zero;
         end
         3'b001: begin
            branch_ok    = 1'b1;
            branch_taken = ~ctrl.Zero;
         end
         default: begin
            branch_ok    = 1'b0;
            branch_taken = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:     state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            case (ctrl.Instr6_0)
               OP_R:             state_d = S_R_EXEC;
               OP_I:             state_d = S_I_EXEC;
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_BRANCH:        state_d = S_BRANCH;
               OP_JAL:           state_d = S_JAL;
               OP_JALR:          state_d = S_JALR;
               OP_LUI:           state_d = S_LUI;
               default:          state_d = S_ERROR;
            endcase
         end
         S_MEM_ADDR:  state_d = (ctrl.Instr6_0 == OP_LOAD) ? S_LOAD_READ : S_STORE;
         S_LOAD_READ: state_d = S_LOAD_WB;
         S_LOAD_WB:   state_d = S_FETCH;
         S_STORE:     state_d = S_FETCH;
         S_R_EXEC:    state_d = arith_ok ? S_R_WB : S_ERROR;
         S_R_WB:      state_d = S_FETCH;
         S_I_EXEC:    state_d = arith_ok ? S_I_WB : S_ERROR;
         S_I_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = branch_ok ? S_FETCH : S_ERROR;
         S_JAL:       state_d = S_FETCH;
         S_JALR:      state_d = S_FETCH;
         S_LUI:       state_d = S_FETCH;
         S_ERROR:     state_d = S_ERROR;
         default:     state_d = S_ERROR;
      endcase
   end

   // Reset wins over every transition, including mid-instruction.
   always_ff @(posedge clk) begin
      if (Reset) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      ctrl.PCWrite    = 1'b0;
      ctrl.IRWrite    = 1'b0;
      ctrl.RegWrite   = 1'b0;
      ctrl.DMemWrite  = 1'b0;
      ctrl.LoadAB     = 1'b0;
      ctrl.LoadALUOut = 1'b0;
      ctrl.LoadMDR    = 1'b0;
      ctrl.ALUSrcA    = 2'b00;
      ctrl.ALUSrcB    = 2'b00;
      ctrl.ALUFunct   = ALU_PASSB;
      ctrl.MemToReg   = 2'b00;
      ctrl.PCSource   = 2'b00;
      ctrl.Error      = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctrl.IRWrite  = 1'b1;
            ctrl.PCWrite  = 1'b1;
            ctrl.ALUSrcB  = 2'b01;
            ctrl.ALUFunct = ALU_ADD;
         end
         S_DECODE: begin
            ctrl.LoadAB     = 1'b1;
            ctrl.LoadALUOut = 1'b1;
            ctrl.ALUSrcB    = 2'b10;
            ctrl.ALUFunct   = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.ALUSrcA    = 2'b01;
            ctrl.ALUSrcB    = 2'b10;
            ctrl.ALUFunct   = ALU_ADD;
            ctrl.LoadALUOut = 1'b1;
         end
         S_LOAD_READ: ctrl.LoadMDR = 1'b1;
         S_LOAD_WB: begin
            ctrl.RegWrite = 1'b1;
            ctrl.MemToReg = 2'b01;
         end
         S_STORE: ctrl.DMemWrite = 1'b1;
         S_R_EXEC, S_I_EXEC: begin
            ctrl.ALUSrcA    = 2'b01;
            ctrl.ALUSrcB    = (state_q == S_I_EXEC) ? 2'b10 : 2'b00;
            ctrl.ALUFunct   = arith_funct;
            ctrl.LoadALUOut = 1'b1;
         end
         S_R_WB, S_I_WB: ctrl.RegWrite = 1'b1;
         S_BRANCH: begin
            ctrl.ALUSrcA  = 2'b01;
            ctrl.ALUFunct = ALU_SUB;
            ctrl.PCSource = 2'b01;
            ctrl.PCWrite  = branch_taken;
         end
         S_JAL: begin
            ctrl.RegWrite = 1'b1;
            ctrl.MemToReg = 2'b10;
            ctrl.PCWrite  = 1'b1;
            ctrl.PCSource = 2'b01;
         end
         S_JALR: begin
            ctrl.RegWrite = 1'b1;
            ctrl.MemToReg = 2'b10;
            ctrl.ALUSrcA  = 2'b01;
            ctrl.ALUSrcB  = 2'b10;
            ctrl.ALUFunct = ALU_ADD;
            ctrl.PCWrite  = 1'b1;
         end
         S_LUI: begin
            ctrl.RegWrite = 1'b1;
            ctrl.MemToReg = 2'b11;
         end
         S_ERROR: ctrl.Error = 1'b1;
         default: ;
      endcase
   end

   assign ctrl.state = STATE_W'(state_q);
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control FSM: expected {state, outputs} per cycle
// are queued from a reference model and compared on the falling edge.
module tb_unidade_controle_multiciclo;
   localparam int W = 24;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   unidade_controle_multiciclo_if #(.STATE_W(5)) bif();

   unidade_controle_multiciclo #(.STATE_W(5)) dut (
      .clk   (clk),
      .Reset (Reset),
      .ctrl  (bif)
   );

   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Reference output vector for a state, straight from the control table.
   function automatic logic [18:0] model_out(input logic [4:0] st, input logic [2:0] f3,
                                             input logic f7, input logic z);
      logic pcw, irw, rw, dmw, lab, lalu, lmdr, err;
      logic [1:0] sa, sb, m2r, pcs;
      logic [2:0] fn;
      {pcw, irw, rw, dmw, lab, lalu, lmdr, err} = '0;
      {sa, sb, m2r, pcs} = '0;
      fn = 3'b000;
      case (st)
         5'd1:  begin irw = 1; pcw = 1; sb = 2'b01; fn = 3'b001; end
         5'd2:  begin lab = 1; lalu = 1; sb = 2'b10; fn = 3'b001; end
         5'd3:  begin sa = 2'b01; sb = 2'b10; fn = 3'b001; lalu = 1; end
         5'd4:  lmdr = 1;
         5'd5:  begin rw = 1; m2r = 2'b01; end
         5'd6:  dmw = 1;
         5'd7, 5'd9: begin
            sa = 2'b01; lalu = 1;
            sb = (st == 5'd9) ? 2'b10 : 2'b00;
            if (f3 == 3'b000)      fn = (st == 5'd7 && f7) ? 3'b010 : 3'b001;
            else if (f3 == 3'b111) fn = 3'b011;
            else if (f3 == 3'b110) fn = 3'b100;
            else if (f3 == 3'b100) fn = 3'b101;
         end
         5'd8, 5'd10: rw = 1;
         5'd11: begin
            sa = 2'b01; fn = 3'b010; pcs = 2'b01;
            pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
         end
         5'd12: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 2'b01; end
         5'd13: begin rw = 1; m2r = 2'b10; sa = 2'b01; sb = 2'b10; fn = 3'b001; pcw = 1; end
         5'd14: begin rw = 1; m2r = 2'b11; end
         5'd15: err = 1;
         default: ;
      endcase
      return {pcw, irw, rw, dmw, lab, lalu, lmdr, sa, sb, fn, m2r, pcs, err};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bif.state, bif.PCWrite, bif.IRWrite, bif.RegWrite, bif.DMemWrite, bif.LoadAB,
              bif.LoadALUOut, bif.LoadMDR, bif.ALUSrcA, bif.ALUSrcB, bif.ALUFunct,
              bif.MemToReg, bif.PCSource, bif.Error};
   endfunction

   // seq holds 5-bit state codes, first visited state in the low bits.
   task automatic push_seq(input logic [59:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         logic [4:0] st;
         st = seq[i*5 +: 5];
         exp_q.push_back({st, model_out(st, bif.Funct3, bif.Funct7_5, bif.Zero)});
      end
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z);
      bif.Instr6_0 = op;
      bif.Funct3   = f3;
      bif.Funct7_5 = f7;
      bif.Zero     = z;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp, act;
      Reset = 1'b1;
      set_instr(7'd0, 3'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      push_seq(60'd0, 1);
      exp = exp_q.pop_front(); act = observed(); n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL reset_hold: got %h, expected %h", act, exp);
      end
      Reset = 1'b0;
      @(posedge clk); @(negedge clk);
      push_seq(60'd1, 1);
      exp = exp_q.pop_front(); act = observed(); n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL reset_release: got %h, expected %h", act, exp);
      end
   endtask

   // Called at a falling edge while in FETCH; leaves the bench at the next FETCH.
   task automatic test_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [59:0] seq, input int n);
      logic [W-1:0] exp, act;
      set_instr(op, f3, f7, z);
      push_seq(seq, n);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front(); act = observed(); n_tests++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, act[23:19], act[18:0], exp[23:19], exp[18:0]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_error();
      logic [W-1:0] exp, act;
      set_instr(7'b1111111, 3'd0, 1'b0, 1'b0);
      push_seq({5'd2, 5'd1}, 2);
      push_seq({12{5'd15}}, 10);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front(); act = observed(); n_tests++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL error_hold: got state=%0d outs=%h, expected state=%0d outs=%h",
                     act[23:19], act[18:0], exp[23:19], exp[18:0]);
         end
         @(posedge clk); @(negedge clk);
      end
      Reset = 1'b1;
      @(posedge clk); @(negedge clk);
      push_seq(60'd0, 1);
      exp = exp_q.pop_front(); act = observed(); n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL error_reset: got %h, expected %h", act, exp);
      end
      Reset = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] exp, act;
      set_instr(7'b0000011, 3'd0, 1'b0, 1'b0);
      push_seq({5'd4, 5'd3, 5'd2, 5'd1}, 4);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front(); act = observed(); n_tests++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_load: got %h, expected %h", act, exp);
         end
         if (exp_q.size() == 0) Reset = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      push_seq(60'd0, 1);
      exp = exp_q.pop_front(); act = observed(); n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL reset_mid_state0: got %h, expected %h", act, exp);
      end
      Reset = 1'b0;
      @(posedge clk); @(negedge clk);
      test_instr("resume_lui", 7'b0110111, 3'd0, 1'b0, 1'b0, {5'd14, 5'd2, 5'd1}, 3);
   endtask

   task automatic test_back_to_back();
      logic [2:0] alu_f3[4] = '{3'b000, 3'b111, 3'b110, 3'b100};
      for (int k = 0; k < 24; k++) begin
         logic [2:0] f3;
         logic f7, z;
         f3 = alu_f3[$urandom_range(0, 3)];
         f7 = 1'($urandom_range(0, 1));
         z  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: test_instr("b2b_r", 7'b0110011, f3, f7, z, {5'd8, 5'd7, 5'd2, 5'd1}, 4);
            1: test_instr("b2b_i", 7'b0010011, f3, f7, z, {5'd10, 5'd9, 5'd2, 5'd1}, 4);
            2: test_instr("b2b_load", 7'b0000011, f3, f7, z, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 5);
            3: test_instr("b2b_store", 7'b0100011, f3, f7, z, {5'd6, 5'd3, 5'd2, 5'd1}, 4);
            4: test_instr("b2b_branch", 7'b1100011, {2'b00, f7}, f7, z, {5'd11, 5'd2, 5'd1}, 3);
            5: test_instr("b2b_jal", 7'b1101111, f3, f7, z, {5'd12, 5'd2, 5'd1}, 3);
            6: test_instr("b2b_jalr", 7'b1100111, f3, f7, z, {5'd13, 5'd2, 5'd1}, 3);
            default: test_instr("b2b_lui", 7'b0110111, f3, f7, z, {5'd14, 5'd2, 5'd1}, 3);
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, {5'd8, 5'd7, 5'd2, 5'd1}, 4);
      test_instr("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0, {5'd8, 5'd7, 5'd2, 5'd1}, 4);
      test_instr("i_addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, {5'd10, 5'd9, 5'd2, 5'd1}, 4);
      test_instr("i_xori", 7'b0010011, 3'b100, 1'b0, 1'b0, {5'd10, 5'd9, 5'd2, 5'd1}, 4);
      test_instr("load", 7'b0000011, 3'b011, 1'b0, 1'b0, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 5);
      test_instr("store", 7'b0100011, 3'b011, 1'b0, 1'b0, {5'd6, 5'd3, 5'd2, 5'd1}, 4);
      test_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, {5'd11, 5'd2, 5'd1}, 3);
      test_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, {5'd11, 5'd2, 5'd1}, 3);
      test_instr("bne_taken", 7'b1100011, 3'b001, 1'b0, 1'b0, {5'd11, 5'd2, 5'd1}, 3);
      test_instr("bne_not", 7'b1100011, 3'b001, 1'b0, 1'b1, {5'd11, 5'd2, 5'd1}, 3);
      test_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, {5'd12, 5'd2, 5'd1}, 3);
      test_instr("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, {5'd13, 5'd2, 5'd1}, 3);
      test_instr("lui", 7'b0110111, 3'b000, 1'b0, 1'b0, {5'd14, 5'd2, 5'd1}, 3);
      test_error();
      test_instr("branch_bad_f3", 7'b1100011, 3'b010, 1'b0, 1'b1, {5'd15, 5'd11, 5'd2, 5'd1}, 4);
      Reset = 1'b1;
      @(posedge clk); @(negedge clk);
      Reset = 1'b0;
      @(posedge clk); @(negedge clk);
      test_instr("after_error", 7'b0110011, 3'b111, 1'b0, 1'b0, {5'd8, 5'd7, 5'd2, 5'd1}, 4);
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
